// File: rtl/boot_loader_6502_pkg.sv
// Shared types and constants for the 6502 boot loader: FSM states, error codes
// and host-bus register offsets.
package boot_loader_6502_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_OFF_LO  = 3'd3,
        ST_OFF_HI  = 3'd4,
        ST_PAYLOAD = 3'd5,
        ST_CHECK   = 3'd6
    } loader_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam int CPU_RESET_OFS = 0;
    localparam int RAM_START_OFS = 2;

    // Running frame checksum: plain 8-bit modular sum.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/boot_loader_6502_timeout_counter.sv
// Inter-byte idle watchdog: counts enabled cycles since the last clear and
// flags expiry once TimeoutCycles idle cycles have elapsed.
module loader_timeout_counter #(
    parameter int TimeoutCycles = 50000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TimeoutCycles + 1);
    localparam logic [CW-1:0] LAST = CW'(TimeoutCycles - 1);

    logic [CW-1:0] r_count;

    // Idle-cycle counter; saturates at the limit until the owner leaves busy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clear_i || !enable_i) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign expired_o = enable_i && !clear_i && (r_count == LAST);

endmodule

// File: rtl/boot_loader_6502.sv
// Host-bus loader for the 6502 subsystem: parses a framed byte stream, holds the
// CPU in reset, copies the payload into CPU RAM and releases the CPU on a good checksum.
module boot_loader_6502
    import boot_loader_6502_pkg::*;
#(
    parameter int          BaseAddress   = 0,
    parameter int          address_width = 15,
    parameter int          data_width    = 16,
    parameter int          RamBytes      = 4102,
    parameter logic [7:0]  SyncByte      = 8'hA5,
    parameter int          TimeoutCycles = 50000000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic [address_width-1:0] address_o,
    output logic [data_width-1:0]    data_o,
    output logic                     rd_wr_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [1:0]               err_code_o,
    output logic                     cpu_held_o
);

    localparam logic [address_width-1:0] CPU_RESET_ADDR = address_width'(BaseAddress + CPU_RESET_OFS);
    localparam logic [address_width-1:0] RAM_START_ADDR = address_width'(BaseAddress + RAM_START_OFS);
    localparam logic [data_width-1:0]    DATA_ONE       = data_width'(1);
    localparam logic [16:0]              RAM_LIMIT      = 17'(RamBytes);

    loader_state_t             r_state,   w_state_nxt;
    logic [15:0]               r_len,     w_len_nxt;
    logic [15:0]               r_off,     w_off_nxt;
    logic [15:0]               r_idx,     w_idx_nxt;
    logic [7:0]                r_sum,     w_sum_nxt;
    logic [address_width-1:0]  r_address, w_address_nxt;
    logic [data_width-1:0]     r_data,    w_data_nxt;
    logic                      r_rd_wr,   w_rd_wr_nxt;
    logic                      r_busy,    w_busy_nxt;
    logic                      r_done,    w_done_nxt;
    logic                      r_error,   w_error_nxt;
    logic [1:0]                r_err_code, w_err_code_nxt;
    logic                      r_cpu_held, w_cpu_held_nxt;

    logic                      w_expired;
    logic [15:0]               w_off_full;
    logic [16:0]               w_span;
    logic [7:0]                w_sum_in;
    logic [address_width-1:0]  w_payload_addr;

    loader_timeout_counter #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timeout (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (rx_valid_i),
        .enable_i  (r_busy),
        .expired_o (w_expired)
    );

    assign w_off_full     = {rx_data_i, r_off[7:0]};
    assign w_span         = {1'b0, w_off_full} + {1'b0, r_len};
    assign w_sum_in       = sum8(r_sum, rx_data_i);
    // Range check at OFF_HI guarantees this sum never wraps.
    assign w_payload_addr = RAM_START_ADDR + address_width'(r_off) + address_width'(r_idx);

    // Frame FSM next-state and next bus/status values; bus defaults to idle.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_off_nxt      = r_off;
        w_idx_nxt      = r_idx;
        w_sum_nxt      = r_sum;
        w_address_nxt  = '0;
        w_data_nxt     = '0;
        w_rd_wr_nxt    = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_err_code_nxt = r_err_code;
        w_cpu_held_nxt = r_cpu_held;

        if (r_busy && w_expired) begin
            w_state_nxt    = ST_IDLE;
            w_busy_nxt     = 1'b0;
            w_error_nxt    = 1'b1;
            w_err_code_nxt = ERR_TIMEOUT;
        end else if (rx_valid_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data_i == SyncByte) begin
                        w_state_nxt    = ST_LEN_LO;
                        w_busy_nxt     = 1'b1;
                        w_error_nxt    = 1'b0;
                        w_err_code_nxt = ERR_NONE;
                        w_len_nxt      = 16'd0;
                        w_off_nxt      = 16'd0;
                        w_idx_nxt      = 16'd0;
                        w_sum_nxt      = 8'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LEN_LO: begin
                    w_len_nxt   = {r_len[15:8], rx_data_i};
                    w_sum_nxt   = w_sum_in;
                    w_state_nxt = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    w_len_nxt   = {rx_data_i, r_len[7:0]};
                    w_sum_nxt   = w_sum_in;
                    w_state_nxt = ST_OFF_LO;
                end
                ST_OFF_LO: begin
                    w_off_nxt   = {r_off[15:8], rx_data_i};
                    w_sum_nxt   = w_sum_in;
                    w_state_nxt = ST_OFF_HI;
                end
                ST_OFF_HI: begin
                    w_off_nxt = w_off_full;
                    w_sum_nxt = w_sum_in;
                    if (w_span > RAM_LIMIT) begin
                        w_state_nxt    = ST_IDLE;
                        w_busy_nxt     = 1'b0;
                        w_error_nxt    = 1'b1;
                        w_err_code_nxt = ERR_RANGE;
                    end else begin
                        w_rd_wr_nxt    = 1'b1;
                        w_address_nxt  = CPU_RESET_ADDR;
                        w_data_nxt     = DATA_ONE;
                        w_cpu_held_nxt = 1'b1;
                        w_state_nxt    = (r_len == 16'd0) ? ST_CHECK : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    w_rd_wr_nxt   = 1'b1;
                    w_address_nxt = w_payload_addr;
                    w_data_nxt    = data_width'(rx_data_i);
                    w_sum_nxt     = w_sum_in;
                    w_idx_nxt     = r_idx + 16'd1;
                    if ((r_idx + 16'd1) == r_len) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
                ST_CHECK: begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    if (w_sum_in == 8'd0) begin
                        w_rd_wr_nxt    = 1'b1;
                        w_address_nxt  = CPU_RESET_ADDR;
                        w_data_nxt     = '0;
                        w_cpu_held_nxt = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else begin
                        w_error_nxt    = 1'b1;
                        w_err_code_nxt = ERR_CHECKSUM;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State and registered outputs; reset leaves the bus idle so the CPU reset register keeps its value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_len      <= 16'd0;
            r_off      <= 16'd0;
            r_idx      <= 16'd0;
            r_sum      <= 8'd0;
            r_address  <= '0;
            r_data     <= '0;
            r_rd_wr    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_cpu_held <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_off      <= w_off_nxt;
            r_idx      <= w_idx_nxt;
            r_sum      <= w_sum_nxt;
            r_address  <= w_address_nxt;
            r_data     <= w_data_nxt;
            r_rd_wr    <= w_rd_wr_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_err_code <= w_err_code_nxt;
            r_cpu_held <= w_cpu_held_nxt;
        end
    end

    assign address_o  = r_address;
    assign data_o     = r_data;
    assign rd_wr_o    = r_rd_wr;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign error_o    = r_error;
    assign err_code_o = r_err_code;
    assign cpu_held_o = r_cpu_held;

endmodule
